// File: rtl/wb_pkg.sv
// Shared definitions for the writeback-select stage: source indices,
// default widths, the skid-buffer state encoding and a clog2 helper.
package wb_pkg;

  // Source index constants for the default 5-source configuration
  localparam int WB_SRC_ALU   = 0;
  localparam int WB_SRC_LOAD  = 1;
  localparam int WB_SRC_PC4   = 2;
  localparam int WB_SRC_PCIMM = 3;
  localparam int WB_SRC_IMM   = 4;

  // Default datapath widths
  localparam int WB_XLEN       = 32;
  localparam int WB_REG_ADDR_W = 5;

  // Occupancy states of the 2-entry skid buffer
  typedef enum logic [1:0] {
    WB_EMPTY = 2'd0,
    WB_ONE   = 2'd1,
    WB_FULL  = 2'd2
  } wb_skid_state_e;

  // Ceiling log2 with a floor of 1 so a select port never collapses to zero bits
  function automatic int wb_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. The main register drives the
// output; the skid register catches the one beat that can arrive after the
// downstream stalls. in_ready and out_valid are registered decodes of the
// next state, so there is no combinational path from out_ready to in_ready.
module wb_skid_buf
  import wb_pkg::*;
#(
  parameter int W = 38
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  wb_skid_state_e state_q, state_d;
  logic [W-1:0]   main_q, main_d;
  logic [W-1:0]   skid_q, skid_d;
  logic           in_ready_q;
  logic           out_valid_q;
  logic           accept_s;
  logic           emit_s;

  assign accept_s  = in_valid && in_ready_q;
  assign emit_s    = out_valid_q && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

  // Next-state and storage-update decision for the occupancy FSM
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      WB_EMPTY: begin
        if (accept_s) begin
          main_d  = in_data;
          state_d = WB_ONE;
        end else begin
          state_d = WB_EMPTY;
        end
      end
      WB_ONE: begin
        if (accept_s && emit_s) begin
          main_d  = in_data;
          state_d = WB_ONE;
        end else if (emit_s) begin
          state_d = WB_EMPTY;
        end else if (accept_s) begin
          skid_d  = in_data;
          state_d = WB_FULL;
        end else begin
          state_d = WB_ONE;
        end
      end
      WB_FULL: begin
        if (emit_s) begin
          main_d  = skid_q;
          state_d = WB_ONE;
        end else begin
          state_d = WB_FULL;
        end
      end
      default: begin
        state_d = WB_EMPTY;
      end
    endcase
  end

  // State, payload and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WB_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != WB_FULL);
      out_valid_q <= (state_d != WB_EMPTY);
    end
  end

endmodule

// File: rtl/wb_select_pipe.sv
// Writeback-select stage: picks one of NUM_SRC result sources by an encoded
// select and hands {we, rd, data} to a 2-entry skid buffer so the register
// file write port can stall without losing results. An illegal select
// zeroes data and write enable and raises a sticky sel_err.
// Optional build macro WB_X0_SUPPRESS_EN: clears the write enable of any
// beat targeting register 0 at accept time.
module wb_select_pipe
  import wb_pkg::*;
#(
  parameter  int XLEN       = WB_XLEN,
  parameter  int NUM_SRC    = 5,
  parameter  int REG_ADDR_W = WB_REG_ADDR_W,
  localparam int SEL_W      = wb_clog2(NUM_SRC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic [NUM_SRC*XLEN-1:0] in_src,
  input  logic [REG_ADDR_W-1:0]   in_rd,
  input  logic                    in_we,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_data,
  output logic [REG_ADDR_W-1:0]   out_rd,
  output logic                    out_we,
  output logic                    sel_err
);

  localparam int PW = XLEN + REG_ADDR_W + 1;

  logic [XLEN-1:0] sel_data_s;
  logic            sel_legal_s;
  logic            we_s;
  logic [PW-1:0]   payload_s;
  logic [PW-1:0]   out_payload_s;
  logic            sel_err_q;

  // One-hot AND-OR mux; an out-of-range select matches no source and yields 0
  always_comb begin
    sel_data_s  = '0;
    sel_legal_s = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      sel_data_s  = sel_data_s | ({XLEN{in_sel == SEL_W'(k)}} & in_src[k*XLEN +: XLEN]);
      sel_legal_s = sel_legal_s | (in_sel == SEL_W'(k));
    end
  end

  // Write enable qualification: illegal selects never write
  always_comb begin
`ifdef WB_X0_SUPPRESS_EN
    we_s = in_we && sel_legal_s && (in_rd != '0);
`else
    we_s = in_we && sel_legal_s;
`endif
  end

  assign payload_s = {we_s, in_rd, sel_data_s};

  wb_skid_buf #(
    .W (PW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (payload_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload_s)
  );

  assign out_data = out_payload_s[XLEN-1:0];
  assign out_rd   = out_payload_s[XLEN +: REG_ADDR_W];
  assign out_we   = out_payload_s[PW-1];
  assign sel_err  = sel_err_q;

  // Sticky flag: set by any accepted beat with an out-of-range select
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else if (in_valid && in_ready && !sel_legal_s) begin
      sel_err_q <= 1'b1;
    end else begin
      sel_err_q <= sel_err_q;
    end
  end

endmodule

// File: tb/tb_wb_select_pipe.sv
// Scoreboard bench for wb_select_pipe (XLEN=32, NUM_SRC=5, REG_ADDR_W=5).
// Expected beats are pushed when the bench sees an accept and compared
// against the output head every cycle the output is valid.
module tb_wb_select_pipe;
  import wb_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_sel = 3'd0;
  logic [159:0] in_src = '0;
  logic [4:0]   in_rd = 5'd0;
  logic         in_we = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_data;
  logic [4:0]   out_rd;
  logic         out_we;
  logic         sel_err;

  beat_t exp_q[$];
  int    n_tests = 0;
  int    n_fail = 0;
  logic  mon_en = 1'b0;
  logic  exp_err = 1'b0;

  wb_select_pipe #(
    .XLEN       (32),
    .NUM_SRC    (5),
    .REG_ADDR_W (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_src    (in_src),
    .in_rd     (in_rd),
    .in_we     (in_we),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .out_we    (out_we),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic beat_t model_beat(input logic [2:0] sel, input logic [159:0] src,
                                       input logic [4:0] rd, input logic we);
    beat_t b;
    b.rd   = rd;
    b.we   = we;
    b.data = 32'd0;
    if (int'(sel) < 5) begin
      b.data = src[int'(sel)*32 +: 32];
    end else begin
      b.we = 1'b0;
    end
`ifdef WB_X0_SUPPRESS_EN
    if (rd == 5'd0) b.we = 1'b0;
`endif
    return b;
  endfunction

  // Monitor / scoreboard, sampled away from the active edge
  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      exp_q.delete();
      exp_err = 1'b0;
    end else if (mon_en) begin
      check_eq("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      check_eq("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      check_eq("sel_err", 64'(sel_err), 64'(exp_err));
      if (out_valid && exp_q.size() > 0) begin
        b = exp_q[0];
        check_eq("out_data", 64'(out_data), 64'(b.data));
        check_eq("out_rd", 64'(out_rd), 64'(b.rd));
        check_eq("out_we", 64'(out_we), 64'(b.we));
        if (out_ready) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model_beat(in_sel, in_src, in_rd, in_we));
        if (int'(in_sel) >= 5) exp_err = 1'b1;
      end
    end
  end

  task automatic set_src(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [31:0] s3, input logic [31:0] s4);
    in_src = {s4, s3, s2, s1, s0};
  endtask

  // Present a beat and hold it until accepted (bounded wait)
  task automatic send(input logic [2:0] sel, input logic [4:0] rd, input logic we);
    int waited;
    bit done;
    waited = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_sel = sel;
    in_rd = rd;
    in_we = we;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      waited++;
      if (!done && waited > 50) begin
        check_eq("send_timeout", 64'(in_ready), 64'd1);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_out_rd", 64'(out_rd), 64'd0);
    check_eq("rst_out_we", 64'(out_we), 64'd0);
    check_eq("rst_sel_err", 64'(sel_err), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);

    // 1: single beat from the load source
    set_src(32'h1, 32'hDEADBEEF, 32'h2, 32'h3, 32'h4);
    send(3'(WB_SRC_LOAD), 5'd7, 1'b1);
    check_eq("t1_valid", 64'(out_valid), 64'd1);
    check_eq("t1_data", 64'(out_data), 64'hDEADBEEF);
    check_eq("t1_rd", 64'(out_rd), 64'd7);
    check_eq("t1_we", 64'(out_we), 64'd1);

    // 2: back-to-back stream, sel cycling through every source
    for (int i = 0; i < 8; i++) begin
      set_src($urandom, $urandom, $urandom, $urandom, $urandom);
      send(3'(i % 5), 5'(i + 1), 1'b1);
    end
    repeat (2) @(posedge clk);
    #1;

    // 3: backpressure for 3 cycles during a stream
    fork
      begin
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      begin
        for (int j = 0; j < 4; j++) begin
          set_src($urandom, $urandom, $urandom, $urandom, $urandom);
          send(3'(j), 5'(10 + j), 1'b1);
        end
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // 4: illegal select, then legal beats with sel_err held
    set_src(32'h11, 32'h22, 32'h33, 32'h44, 32'h55);
    send(3'd6, 5'd9, 1'b1);
    check_eq("t4_data", 64'(out_data), 64'd0);
    check_eq("t4_we", 64'(out_we), 64'd0);
    check_eq("t4_sel_err", 64'(sel_err), 64'd1);
    send(3'(WB_SRC_IMM), 5'd4, 1'b1);
    send(3'(WB_SRC_ALU), 5'd5, 1'b1);
    check_eq("t4_sel_err_held", 64'(sel_err), 64'd1);
    repeat (2) @(posedge clk);
    #1;

    // 5: reset while FULL
    out_ready = 1'b0;
    send(3'd2, 5'd20, 1'b1);
    send(3'd3, 5'd21, 1'b1);
    check_eq("t5_full", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("t5_out_valid", 64'(out_valid), 64'd0);
    check_eq("t5_in_ready", 64'(in_ready), 64'd1);
    check_eq("t5_sel_err", 64'(sel_err), 64'd0);
    out_ready = 1'b1;
    set_src(32'hCAFE0001, 32'h0, 32'h0, 32'h0, 32'h0);
    send(3'd0, 5'd3, 1'b1);
    check_eq("t5_after_data", 64'(out_data), 64'hCAFE0001);
    check_eq("t5_after_rd", 64'(out_rd), 64'd3);

    // 6: write to register 0
    set_src(32'h5, 32'h6, 32'h7, 32'h8, 32'h9);
    send(3'(WB_SRC_ALU), 5'd0, 1'b1);
    check_eq("t6_data", 64'(out_data), 64'h5);
`ifdef WB_X0_SUPPRESS_EN
    check_eq("t6_we", 64'(out_we), 64'd0);
`else
    check_eq("t6_we", 64'(out_we), 64'd1);
`endif

    repeat (3) @(posedge clk);
    #1;
    check_eq("drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
